// File: rtl/dcache_direct_pkg.sv
// dcache_direct_pkg: line geometry and FSM state encodings shared by the data cache files.
// Latency: n/a (types, constants and width helpers only).
// Backpressure: n/a.
package dcache_direct_pkg;

   localparam int LINE_BYTES     = 32;
   localparam int OFF_W          = $clog2(LINE_BYTES);
   localparam int WORDS_PER_LINE = LINE_BYTES / 4;
   localparam int WSEL_W         = $clog2(WORDS_PER_LINE);

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_WB      = 3'd1,
      ST_REFILL  = 3'd2,
      ST_FL_SCAN = 3'd3,
      ST_FL_WB   = 3'd4
   } state_e;

   function automatic int idx_width(input int num_lines);
      return $clog2(num_lines);
   endfunction

   function automatic int tag_width(input int num_lines);
      return 32 - OFF_W - $clog2(num_lines);
   endfunction

endpackage

// File: rtl/dcache_byte_merge.sv
// dcache_byte_merge: big-endian merge of 1..4 store bytes into a 32-bit cache word.
// Latency: combinational.  Backpressure: none.
// Ports: old_word_i (current word), wdata_i (low N bytes used), size_i (0 = 4 bytes),
//        addr_lo_i (byte offset in word), merged_o (result).
module dcache_byte_merge (
   input  logic [31:0] old_word_i,
   input  logic [31:0] wdata_i,
   input  logic [1:0]  size_i,
   input  logic [1:0]  addr_lo_i,
   output logic [31:0] merged_o
);

   // Byte lane 0 is the most significant byte of the word. The first store byte
   // (MSB of the N low bytes) lands at the addressed lane; lanes past 3 are dropped.
   always_comb begin
      int nbytes;
      int off;
      int k;
      merged_o = old_word_i;
      nbytes   = (size_i == 2'd0) ? 4 : int'(size_i);
      off      = int'(addr_lo_i);
      k        = 0;
      for (int lane = 0; lane < 4; lane++) begin
         k = lane - off;
         if (k >= 0 && k < nbytes) begin
            merged_o[(3 - lane) * 8 +: 8] = wdata_i[(nbytes - 1 - k) * 8 +: 8];
         end
      end
   end

endmodule

// File: rtl/dcache_direct.sv
// dcache_direct: direct-mapped write-back/write-allocate data cache, word side to 256-bit block side.
// Latency: zero-cycle hit; miss serves 1 cycle after the refill valid (after a writeback if dirty).
// Backpressure: data_valid_fDC low stalls MEM; block requests held until *_fDM_valid.
// Ports: CLK/RESET (sync, active-high); *_2DC/*_fDC word request side; *_2DM/*_fDM block side;
//        hit_count_fDC/miss_count_fDC counters, live only when DCACHE_STATS_EN is defined.
module dcache_direct
   import dcache_direct_pkg::*;
#(
   parameter int NUM_LINES = 32
) (
   input  logic         CLK,
   input  logic         RESET,
   input  logic [31:0]  data_address_2DC,
   input  logic         read_2DC,
   input  logic         write_2DC,
   input  logic [31:0]  data_write_2DC,
   input  logic [1:0]   data_write_size_2DC,
   input  logic         flush_2DC,
   output logic [31:0]  data_read_fDC,
   output logic         data_valid_fDC,
   output logic         flush_done_fDC,
   output logic [31:0]  data_address_2DM,
   output logic         dBlkRead,
   output logic         dBlkWrite,
   output logic [255:0] block_write_2DM,
   input  logic [255:0] block_read_fDM,
   input  logic         block_read_fDM_valid,
   input  logic         block_write_fDM_valid,
   output logic [31:0]  hit_count_fDC,
   output logic [31:0]  miss_count_fDC
);

   localparam int IDX_W = idx_width(NUM_LINES);
   localparam int TAG_W = tag_width(NUM_LINES);

   logic [255:0]         data_q [NUM_LINES];
   logic [TAG_W-1:0]     tag_q  [NUM_LINES];
   logic [NUM_LINES-1:0] valid_q, valid_d, dirty_q, dirty_d;
   state_e               state_q, state_d;
   logic [IDX_W-1:0]     fptr_q, fptr_d;
   logic                 farm_q, farm_d;

   logic [IDX_W-1:0]  req_idx, line_idx;
   logic [TAG_W-1:0]  req_tag;
   logic [WSEL_W-1:0] req_word;
   logic [255:0]      cur_line;
   logic [31:0]       old_word, merged_word;
   logic              hit, fl_state;
   logic              line_we, word_we, hit_evt, miss_evt;
   logic              valid_c, done_c, rd_c, wr_c;
   logic [31:0]       rdata_c, baddr_c;

   assign req_idx  = data_address_2DC[OFF_W +: IDX_W];
   assign req_tag  = data_address_2DC[31 -: TAG_W];
   assign req_word = data_address_2DC[2 +: WSEL_W];
   assign fl_state = (state_q == ST_FL_SCAN) || (state_q == ST_FL_WB);
   assign line_idx = fl_state ? fptr_q : req_idx;
   assign cur_line = data_q[line_idx];
   assign old_word = cur_line[{req_word, 5'b0} +: 32];
   assign hit      = valid_q[req_idx] && (tag_q[req_idx] == req_tag);

   dcache_byte_merge u_merge (
      .old_word_i (old_word),
      .wdata_i    (data_write_2DC),
      .size_i     (data_write_size_2DC),
      .addr_lo_i  (data_address_2DC[1:0]),
      .merged_o   (merged_word)
   );

   always_comb begin
      state_d  = state_q;
      valid_d  = valid_q;
      dirty_d  = dirty_q;
      fptr_d   = fptr_q;
      // flush is edge-armed: re-arm only once flush_2DC has been seen low
      farm_d   = flush_2DC ? farm_q : 1'b1;
      valid_c  = 1'b0;
      done_c   = 1'b0;
      rd_c     = 1'b0;
      wr_c     = 1'b0;
      rdata_c  = '0;
      baddr_c  = '0;
      line_we  = 1'b0;
      word_we  = 1'b0;
      hit_evt  = 1'b0;
      miss_evt = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (flush_2DC && farm_q) begin
               farm_d  = 1'b0;
               fptr_d  = '0;
               state_d = ST_FL_SCAN;
            end else if (write_2DC || read_2DC) begin
               if (hit) begin
                  valid_c = 1'b1;
                  hit_evt = 1'b1;
                  if (write_2DC) begin
                     word_we          = 1'b1;
                     dirty_d[req_idx] = 1'b1;
                  end else begin
                     rdata_c = old_word;
                  end
               end else begin
                  miss_evt = 1'b1;
                  state_d  = (valid_q[req_idx] && dirty_q[req_idx]) ? ST_WB : ST_REFILL;
               end
            end else begin
               valid_c = 1'b1;
            end
         end
         ST_WB: begin
            wr_c    = 1'b1;
            baddr_c = {tag_q[req_idx], req_idx, {OFF_W{1'b0}}};
            if (block_write_fDM_valid) begin
               dirty_d[req_idx] = 1'b0;
               state_d          = ST_REFILL;
            end
         end
         ST_REFILL: begin
            rd_c    = 1'b1;
            baddr_c = {req_tag, req_idx, {OFF_W{1'b0}}};
            if (block_read_fDM_valid) begin
               line_we          = 1'b1;
               valid_d[req_idx] = 1'b1;
               dirty_d[req_idx] = 1'b0;
               state_d          = ST_IDLE;
            end
         end
         ST_FL_SCAN: begin
            if (valid_q[fptr_q] && dirty_q[fptr_q]) begin
               state_d = ST_FL_WB;
            end else begin
               valid_d[fptr_q] = 1'b0;
               if (&fptr_q) begin
                  done_c  = 1'b1;
                  state_d = ST_IDLE;
               end else begin
                  fptr_d = fptr_q + 1'b1;
               end
            end
         end
         ST_FL_WB: begin
            wr_c    = 1'b1;
            baddr_c = {tag_q[fptr_q], fptr_q, {OFF_W{1'b0}}};
            if (block_write_fDM_valid) begin
               valid_d[fptr_q] = 1'b0;
               dirty_d[fptr_q] = 1'b0;
               if (&fptr_q) begin
                  done_c  = 1'b1;
                  state_d = ST_IDLE;
               end else begin
                  fptr_d  = fptr_q + 1'b1;
                  state_d = ST_FL_SCAN;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Outputs are forced low while RESET is high so an in-flight transaction aborts at once.
   assign data_valid_fDC   = valid_c & ~RESET;
   assign data_read_fDC    = RESET ? 32'd0 : rdata_c;
   assign flush_done_fDC   = done_c & ~RESET;
   assign dBlkRead         = rd_c & ~RESET;
   assign dBlkWrite        = wr_c & ~RESET;
   assign data_address_2DM = RESET ? 32'd0 : baddr_c;
   assign block_write_2DM  = (wr_c && !RESET) ? cur_line : '0;

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q <= ST_IDLE;
         valid_q <= '0;
         dirty_q <= '0;
         fptr_q  <= '0;
         farm_q  <= 1'b1;
      end else begin
         state_q <= state_d;
         valid_q <= valid_d;
         dirty_q <= dirty_d;
         fptr_q  <= fptr_d;
         farm_q  <= farm_d;
      end
   end

   // Data and tag storage carry no reset; valid bits gate their use.
   always_ff @(posedge CLK) begin
      if (!RESET && line_we) begin
         data_q[req_idx] <= block_read_fDM;
         tag_q[req_idx]  <= req_tag;
      end else if (!RESET && word_we) begin
         data_q[req_idx][{req_word, 5'b0} +: 32] <= merged_word;
      end
   end

`ifdef DCACHE_STATS_EN
   logic [31:0] hit_cnt_q, miss_cnt_q;
   logic        missed_q;  // the pending request already took a miss; its service is not a hit

   always_ff @(posedge CLK) begin
      if (RESET) begin
         hit_cnt_q  <= '0;
         miss_cnt_q <= '0;
         missed_q   <= 1'b0;
      end else begin
         if (miss_evt) begin
            missed_q <= 1'b1;
         end else if (hit_evt) begin
            missed_q <= 1'b0;
         end
         if (hit_evt && !missed_q && hit_cnt_q != 32'hFFFF_FFFF) begin
            hit_cnt_q <= hit_cnt_q + 32'd1;
         end
         if (miss_evt && miss_cnt_q != 32'hFFFF_FFFF) begin
            miss_cnt_q <= miss_cnt_q + 32'd1;
         end
      end
   end

   assign hit_count_fDC  = RESET ? 32'd0 : hit_cnt_q;
   assign miss_count_fDC = RESET ? 32'd0 : miss_cnt_q;
`else
   logic unused_stats;
   assign unused_stats   = hit_evt ^ miss_evt;
   assign hit_count_fDC  = 32'd0;
   assign miss_count_fDC = 32'd0;
`endif

endmodule
